// File: rtl/buffer_ctrl_pkg.sv
// Shared definitions for the convolution sample-buffer controller:
// controller state encoding and the taps-to-pairs helper.
package buffer_ctrl_pkg;

  typedef enum logic {
    FILL = 1'b0,
    READ = 1'b1
  } state_t;

  // Pair_* flags travel as one bundle: {valid, second_valid, first, last}
  localparam int FLAG_W = 4;

  function automatic int num_pairs(input int kernel_size);
    return (kernel_size + 1) / 2;
  endfunction

endpackage

// File: rtl/buffer_ctrl_flag_delay.sv
// Latency-deep shift register for the pair flag bundle, with synchronous clear.
// Latency=0 is a pure wire so flags line up with a combinational Buffer read.
module buffer_ctrl_flag_delay #(
  parameter int Latency = 1,
  parameter int Width   = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  generate
    if (Latency == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, srst};
      assign q = d;
    end else begin : g_pipe
      for (genvar gi = 0; gi < Latency; gi++) begin : g_stage
        logic [Width-1:0] q_reg;
        if (gi == 0) begin : g_head
          always_ff @(posedge clk) begin
            if (srst) q_reg <= '0;
            else      q_reg <= d;
          end
        end else begin : g_tail
          always_ff @(posedge clk) begin
            if (srst) q_reg <= '0;
            else      q_reg <= g_stage[gi-1].q_reg;
          end
        end
      end
      assign q = g_stage[Latency-1].q_reg;
    end
  endgenerate

endmodule

// File: rtl/buffer_ctrl.sv
// Sample-buffer address sequencer: fills a KernelSize window, streams it two taps
// per cycle, slides by Stride. Optional macro BUFFER_CTRL_WINCNT_EN adds Window_Count.
module buffer_ctrl
  import buffer_ctrl_pkg::*;
#(
  parameter int BufferSize  = 4,
  parameter int BufferWidth = 2,
  parameter int KernelSize  = 3,
  parameter int Stride      = 1,
  parameter int ReadLatency = 1
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   Flush,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  output logic                   EN,
  output logic [BufferWidth-1:0] W_Addr,
  output logic [BufferWidth-1:0] R_Addr1,
  output logic [BufferWidth-1:0] R_Addr2,
  output logic                   Pair_Valid,
  output logic                   Pair_Second_Valid,
  output logic                   Pair_First,
  output logic                   Pair_Last,
  output logic                   Busy
`ifdef BUFFER_CTRL_WINCNT_EN
  ,
  output logic [15:0]            Window_Count
`endif
);

  localparam int CW = BufferWidth + 1;
  localparam logic [BufferWidth-1:0] LAST_PAIR = BufferWidth'(num_pairs(KernelSize) - 1);
  localparam logic [BufferWidth-1:0] STRIDE_A  = BufferWidth'(Stride);
  localparam logic [CW-1:0]          STRIDE_C  = CW'(Stride);
  localparam logic [CW-1:0]          KERNEL_C  = CW'(KernelSize);
  localparam bit                     KERNEL_ODD = (KernelSize % 2) == 1;

  state_t                 state_reg, state_next;
  logic [BufferWidth-1:0] wptr_reg, wptr_next;
  logic [BufferWidth-1:0] rbase_reg, rbase_next;
  logic [CW-1:0]          count_reg, count_next;
  logic [BufferWidth-1:0] pair_idx_reg, pair_idx_next;
  logic [BufferWidth-1:0] r_addr1_reg, r_addr2_reg;

  logic                   in_ready, en, is_last;
  logic [BufferWidth-1:0] tap_even, tap_odd;
  logic                   raw_valid, raw_second, raw_first, raw_last;
  logic [FLAG_W-1:0]      raw_flags, pair_flags;

  assign in_ready = (state_reg == FILL) && !Flush && !aclr;
  assign en       = In_Valid && in_ready;
  assign tap_even = rbase_reg + (pair_idx_reg << 1);
  assign tap_odd  = tap_even + BufferWidth'(1);
  assign is_last  = (pair_idx_reg == LAST_PAIR);

  // Aborted reads must never surface as valid pairs, even with zero read latency
  assign raw_valid  = (state_reg == READ) && !Flush && !aclr;
  assign raw_first  = raw_valid && (pair_idx_reg == '0);
  assign raw_last   = raw_valid && is_last;
  assign raw_second = raw_valid && !(is_last && KERNEL_ODD);
  assign raw_flags  = {raw_valid, raw_second, raw_first, raw_last};

  always_comb begin
    state_next    = state_reg;
    wptr_next     = wptr_reg;
    rbase_next    = rbase_reg;
    count_next    = count_reg;
    pair_idx_next = pair_idx_reg;
    if (Flush) begin
      state_next    = FILL;
      count_next    = '0;
      pair_idx_next = '0;
      rbase_next    = wptr_reg;
    end else begin
      unique case (state_reg)
        FILL: begin
          if (en) begin
            wptr_next  = wptr_reg + BufferWidth'(1);
            count_next = count_reg + CW'(1);
            if (count_next == KERNEL_C) state_next = READ;
          end
        end
        READ: begin
          if (is_last) begin
            rbase_next    = rbase_reg + STRIDE_A;
            count_next    = count_reg - STRIDE_C;
            pair_idx_next = '0;
            state_next    = FILL;
          end else begin
            pair_idx_next = pair_idx_reg + BufferWidth'(1);
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_reg    <= FILL;
      wptr_reg     <= '0;
      rbase_reg    <= '0;
      count_reg    <= '0;
      pair_idx_reg <= '0;
      r_addr1_reg  <= '0;
      r_addr2_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wptr_reg     <= wptr_next;
      rbase_reg    <= rbase_next;
      count_reg    <= count_next;
      pair_idx_reg <= pair_idx_next;
      if (state_reg == READ) begin
        r_addr1_reg <= tap_even;
        r_addr2_reg <= tap_odd;
      end
    end
  end

  buffer_ctrl_flag_delay #(
    .Latency (ReadLatency),
    .Width   (FLAG_W)
  ) u_flag_delay (
    .clk  (clk),
    .srst (aclr | Flush),
    .d    (raw_flags),
    .q    (pair_flags)
  );

  assign In_Ready          = in_ready;
  assign EN                = en;
  assign W_Addr            = wptr_reg;
  assign R_Addr1           = (state_reg == READ) ? tap_even : r_addr1_reg;
  assign R_Addr2           = (state_reg == READ) ? tap_odd  : r_addr2_reg;
  assign Pair_Valid        = pair_flags[3];
  assign Pair_Second_Valid = pair_flags[2];
  assign Pair_First        = pair_flags[1];
  assign Pair_Last         = pair_flags[0];
  assign Busy              = (state_reg != FILL);

`ifdef BUFFER_CTRL_WINCNT_EN
  logic [15:0] window_count_reg;

  always_ff @(posedge clk) begin
    if (aclr || Flush)                window_count_reg <= '0;
    else if (Pair_Valid && Pair_Last) window_count_reg <= window_count_reg + 16'd1;
  end

  assign Window_Count = window_count_reg;
`endif

endmodule
